// File: rtl/align_out_buffer_pkg.sv
// Shared NW definitions: symbol and state encodings, default sizes and the
// LIFO word layout used by the traceback output buffer.
package align_out_buffer_pkg;

    localparam int unsigned NDefault     = 128;
    localparam int unsigned DefaultDepth = 2 * NDefault;
    localparam int unsigned SymW         = 3;

    typedef logic [SymW-1:0] sym_t;

    localparam sym_t SymA   = 3'b000;
    localparam sym_t SymC   = 3'b001;
    localparam sym_t SymG   = 3'b010;
    localparam sym_t SymT   = 3'b011;
    localparam sym_t SymGap = 3'b100;

    localparam logic [1:0] StCollect = 2'd0;
    localparam logic [1:0] StDrain   = 2'd1;
    localparam logic [1:0] StFlush   = 2'd2;

    typedef struct packed {
        sym_t a;
        sym_t b;
    } pair_t;

endpackage

// File: rtl/lifo_ram.sv
// Pair storage for the traceback LIFO: synchronous write, registered read.
// The array is not reset; only the read register is.
module lifo_ram
    import align_out_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  pair_t            wr_data,
    input  logic             rd_en,
    input  logic [AddrW-1:0] rd_addr,
    output pair_t            rd_data
);

    pair_t mem_q [DEPTH];
    pair_t rd_data_q;
    pair_t rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds while not enabled so a stalled beat stays stable.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/align_out_buffer.sv
// Reverses traceback pairs (emitted end-to-start) into forward alignment order
// and streams them out with valid/ready, latching the final score and length.
module align_out_buffer
    import align_out_buffer_pkg::*;
#(
    parameter int unsigned N       = NDefault,
    parameter int unsigned BitAddr = $clog2(N + 1),
    parameter int unsigned DEPTH   = 2 * N
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [SymW-1:0]              in_a,
    input  logic [SymW-1:0]              in_b,
    input  logic                         in_last,
    input  logic signed [BitAddr:0]      in_score,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [SymW-1:0]              out_a,
    output logic [SymW-1:0]              out_b,
    output logic                         out_last,
    output logic signed [BitAddr:0]      out_score,
    output logic [$clog2(DEPTH+1)-1:0]   out_len,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int unsigned PtrW  = $clog2(DEPTH + 1);
    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] DepthP = PtrW'(DEPTH);
    localparam logic [PtrW-1:0] OneP   = PtrW'(1);

    logic [1:0]              state_q, state_d;
    logic [PtrW-1:0]         count_q, count_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic signed [BitAddr:0] out_score_q, out_score_d;
    logic [PtrW-1:0]         out_len_q, out_len_d;

    logic       wr_en, rd_en, fire;
    pair_t      wr_data, rd_data;
    logic [AddrW-1:0] wr_addr, rd_addr;

    assign fire    = out_valid_q && out_ready;
    assign wr_data = '{a: in_a, b: in_b};
    assign wr_addr = AddrW'(count_q);
    assign rd_addr = AddrW'(count_q - OneP);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;
        out_score_d = out_score_q;
        out_len_d   = out_len_q;
        done_d      = (state_q == StFlush);
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        case (state_q)
            StCollect: begin
                if (in_valid) begin
                    if (count_q < DepthP) begin
                        wr_en   = 1'b1;
                        count_d = count_q + OneP;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // count_d already includes a pair pushed alongside in_last.
                if (in_last) begin
                    out_score_d = in_score;
                    out_len_d   = count_d;
                    state_d     = (count_d != '0) ? StDrain : StFlush;
                end
            end
            StDrain: begin
                if (in_valid || in_last) begin
                    overflow_d = 1'b1;
                end
                if (fire) begin
                    out_valid_d = 1'b0;
                end
                // Refill the read register whenever it is empty or being consumed.
                if (count_q != '0 && (!out_valid_q || fire)) begin
                    rd_en       = 1'b1;
                    count_d     = count_q - OneP;
                    out_valid_d = 1'b1;
                    out_last_d  = (count_q == OneP);
                end
                if (fire && out_last_q) begin
                    out_last_d = 1'b0;
                    state_d    = StFlush;
                end
            end
            StFlush: begin
                if (in_valid || in_last) begin
                    overflow_d = 1'b1;
                end
                count_d = '0;
                state_d = StCollect;
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StCollect;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_score_q <= '0;
            out_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            out_score_q <= out_score_d;
            out_len_q   <= out_len_d;
        end
    end

    lifo_ram #(
        .DEPTH (DEPTH),
        .AddrW (AddrW)
    ) u_lifo_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_a     = rd_data.a;
    assign out_b     = rd_data.b;
    assign out_score = out_score_q;
    assign out_len   = out_len_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != StCollect);

endmodule

// File: tb/tb_align_out_buffer.sv
// Bench for align_out_buffer: directed traceback runs plus randomized ones,
// checked against a reversed-queue model of the pushed pairs.
module tb_align_out_buffer;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int BA    = 3;
    localparam logic [2:0] A = 3'd0, C = 3'd1, G = 3'd2, T = 3'd3, GAP = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [2:0] in_a = '0, in_b = '0;
    logic signed [BA:0] in_score = '0;
    logic out_valid, out_last, busy, done, overflow;
    logic [2:0] out_a, out_b;
    logic signed [BA:0] out_score;
    logic [3:0] out_len;

    always #5 clk = ~clk;

    align_out_buffer #(.N(N), .BitAddr(BA), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .in_score  (in_score),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last),
        .out_score (out_score),
        .out_len   (out_len),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Model: pairs to push, and the expected forward-order beats.
    logic [2:0] stim_a[$], stim_b[$];
    logic [2:0] exp_a[$], exp_b[$];
    // Observations gathered by collect().
    logic [2:0] got_a[$], got_b[$];
    logic       got_last[$];
    int first_lat, done_cnt, done_lat, stable_err, busy_err;

    task automatic push_run(input bit last_with_push, input logic signed [BA:0] score);
        int n;
        n = stim_a.size();
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < n; i++) begin
            if (i < DEPTH) begin
                exp_a.push_front(stim_a[i]);
                exp_b.push_front(stim_b[i]);
            end
            in_valid = 1'b1;
            in_a     = stim_a[i];
            in_b     = stim_b[i];
            in_last  = last_with_push && (i == n - 1);
            in_score = score;
            @(posedge clk); #1;
        end
        if (!last_with_push || n == 0) begin
            in_valid = 1'b0;
            in_last  = 1'b1;
            in_score = score;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        stim_a.delete();
        stim_b.delete();
    endtask

    // Observes from the cycle after in_last; mode 0: ready=1, 1: 1,0,0,1,1, 2: random.
    task automatic collect(input int mode);
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int idx = 0;
        bit r, pv = 0, pr = 0, pl = 0;
        logic [2:0] pa = '0, pb = '0;
        got_a.delete(); got_b.delete(); got_last.delete();
        first_lat = -1; done_cnt = 0; done_lat = -1; stable_err = 0; busy_err = 0;
        for (int c = 1; c < 200; c++) begin
            if (done_cnt > 0 && c >= done_lat + 3) break;
            if (done) begin
                done_cnt++;
                done_lat = c;
            end
            if (out_valid && first_lat < 0) first_lat = c;
            if (out_valid && !busy) busy_err++;
            if (pv && !pr && (!out_valid || out_a !== pa || out_b !== pb || out_last !== pl))
                stable_err++;
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = (first_lat < 0) ? 1'b1 : pat[idx % 5];
            else r = ($urandom_range(0, 2) != 0);
            if (first_lat >= 0) idx++;
            out_ready = r;
            if (out_valid && r) begin
                got_a.push_back(out_a);
                got_b.push_back(out_b);
                got_last.push_back(out_last);
            end
            pv = out_valid; pr = r; pa = out_a; pb = out_b; pl = out_last;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, out_last, done, busy, overflow, out_a, out_b, out_score, out_len} !== '0)
        begin
            errors++;
            $display("FAIL reset_state: got %b/%b/%b/%b/%b a=%0d b=%0d s=%0d l=%0d want all 0",
                     out_valid, out_last, done, busy, overflow, out_a, out_b, out_score, out_len);
        end
    endtask

    task automatic test_basic();
        stim_a = '{A, C, G};
        stim_b = '{A, GAP, G};
        push_run(1'b0, 4'sd1);
        collect(0);
        checks++;
        if (got_a.size() != 3) begin
            errors++; $display("FAIL basic_count: got %0d beats want 3", got_a.size());
        end
        for (int i = 0; i < got_a.size() && i < 3; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL basic_beat%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, got_a[i],
                         got_b[i], got_last[i], exp_a[i], exp_b[i], i == 2);
            end
        end
        checks++;
        if (out_len !== 4'd3 || out_score !== 4'sd1) begin
            errors++; $display("FAIL basic_len_score: got %0d/%0d want 3/1", out_len, out_score);
        end
        checks++;
        if (first_lat != 2 || done_cnt != 1 || busy_err != 0) begin
            errors++;
            $display("FAIL basic_timing: got lat=%0d done=%0d busyerr=%0d want 2/1/0",
                     first_lat, done_cnt, busy_err);
        end
    endtask

    task automatic test_stall();
        stim_a = '{A, C, G};
        stim_b = '{A, GAP, G};
        push_run(1'b0, 4'sd1);
        collect(1);
        checks++;
        if (got_a.size() != 3 || stable_err != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_run: got beats=%0d unstable=%0d done=%0d want 3/0/1",
                     got_a.size(), stable_err, done_cnt);
        end
        for (int i = 0; i < got_a.size() && i < 3; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL stall_beat%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, got_a[i],
                         got_b[i], got_last[i], exp_a[i], exp_b[i], i == 2);
            end
        end
    endtask

    task automatic test_last_with_push();
        stim_a = '{C, T};
        stim_b = '{G, T};
        push_run(1'b1, -4'sd2);
        collect(0);
        checks++;
        if (out_len !== 4'd2 || out_score !== -4'sd2 || got_a.size() != 2) begin
            errors++;
            $display("FAIL lastpush_len: got len=%0d score=%0d beats=%0d want 2/-2/2",
                     out_len, out_score, got_a.size());
        end
        checks++;
        if (got_a.size() < 2 || got_a[0] !== T || got_b[0] !== T || got_a[1] !== C
            || got_b[1] !== G || got_last[1] !== 1'b1 || first_lat != 2) begin
            errors++;
            $display("FAIL lastpush_order: got first=%0d/%0d lat=%0d want 3/3 lat 2",
                     (got_a.size() > 0) ? got_a[0] : 3'd7, (got_b.size() > 0) ? got_b[0] : 3'd7,
                     first_lat);
        end
    endtask

    task automatic test_empty();
        push_run(1'b0, -4'sd8);
        collect(0);
        checks++;
        if (got_a.size() != 0 || first_lat != -1 || done_cnt != 1 || done_lat != 2) begin
            errors++;
            $display("FAIL empty_run: got beats=%0d lat=%0d done=%0d at %0d want 0/-1/1 at 2",
                     got_a.size(), first_lat, done_cnt, done_lat);
        end
        checks++;
        if (out_score !== -4'sd8 || out_len !== 4'd0) begin
            errors++; $display("FAIL empty_score: got %0d/%0d want -8/0", out_score, out_len);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            logic signed [BA:0] s;
            n = $urandom_range(1, DEPTH);
            s = BA'($urandom_range(0, 15));
            for (int i = 0; i < n; i++) begin
                stim_a.push_back(3'($urandom_range(0, 4)));
                stim_b.push_back(3'($urandom_range(0, 4)));
            end
            push_run(1'($urandom_range(0, 1)), s);
            collect(2);
            checks++;
            if (got_a.size() != n || out_len !== 4'(n) || out_score !== s || stable_err != 0
                || first_lat != 2 || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_run: got beats=%0d len=%0d score=%0d unstable=%0d lat=%0d done=%0d want %0d/%0d/%0d/0/2/1",
                         it, got_a.size(), out_len, out_score, stable_err, first_lat, done_cnt,
                         n, n, s);
            end
            for (int i = 0; i < got_a.size() && i < n; i++) begin
                checks++;
                if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_last[i] !== (i == n - 1))
                begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %0d/%0d/%0d want %0d/%0d/%0d", it, i,
                             got_a[i], got_b[i], got_last[i], exp_a[i], exp_b[i], i == n - 1);
                end
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL rand_no_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) begin
            stim_a.push_back(3'($urandom_range(0, 4)));
            stim_b.push_back(3'($urandom_range(0, 4)));
        end
        push_run(1'b0, 4'sd3);
        collect(0);
        checks++;
        if (overflow !== 1'b1 || out_len !== 4'd8 || got_a.size() != DEPTH) begin
            errors++;
            $display("FAIL overflow_run: got ovf=%b len=%0d beats=%0d want 1/8/8", overflow,
                     out_len, got_a.size());
        end
        for (int i = 0; i < got_a.size() && i < DEPTH; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL overflow_beat%0d: got %0d/%0d want %0d/%0d", i, got_a[i],
                         got_b[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int beats = 0;
        int stray = 0;
        for (int i = 0; i < 5; i++) begin
            stim_a.push_back(3'($urandom_range(0, 3)));
            stim_b.push_back(3'($urandom_range(0, 3)));
        end
        push_run(1'b0, 4'sd5);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            if (out_valid) beats++;
            @(posedge clk); #1;
        end
        checks++;
        if (beats != 2) begin
            errors++; $display("FAIL rst_mid_beats: got %0d beats before reset want 2", beats);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, done, busy, overflow, out_a, out_b, out_score, out_len} !== '0)
        begin
            errors++;
            $display("FAIL rst_mid_zero: got %b/%b/%b/%b/%b a=%0d b=%0d s=%0d l=%0d want all 0",
                     out_valid, out_last, done, busy, overflow, out_a, out_b, out_score, out_len);
        end
        @(posedge clk); #2 rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid || done) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL rst_mid_abandon: got %0d stray cycles want 0", stray);
        end
        stim_a = '{G};
        stim_b = '{C};
        push_run(1'b0, 4'sd1);
        collect(0);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== G || got_b[0] !== C || got_last[0] !== 1'b1
            || out_len !== 4'd1 || out_score !== 4'sd1 || done_cnt != 1 || first_lat != 2) begin
            errors++;
            $display("FAIL rst_mid_rerun: got beats=%0d len=%0d score=%0d done=%0d lat=%0d want 1/1/1/1/2",
                     got_a.size(), out_len, out_score, done_cnt, first_lat);
        end
    endtask

    initial begin
        #3;
        test_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_stall();
        test_last_with_push();
        test_empty();
        test_random();
        test_overflow();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
